// File: rtl/traffic_pkg.sv
// Shared state encoding for the traffic-light controller and its consumers,
// plus the transition legality table used by the lamp decoder's checker.
package traffic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2,
        RED    = 2'd3
    } traffic_state_e;

    localparam int unsigned BLINK_CNT_W = 16;

    function automatic logic is_legal(input traffic_state_e prev, input traffic_state_e next);
        logic ok;
        ok = 1'b0;
        if (next == prev || next == IDLE) begin
            ok = 1'b1;
        end else begin
            case (prev)
                IDLE:    ok = (next == GREEN);
                GREEN:   ok = (next == YELLOW);
                YELLOW:  ok = (next == RED);
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/traffic_lamp_blinker.sv
// Blink phase generator for the IDLE yellow lamp: the phase toggles every
// BLINK_DIV enabled cycles; disabling clears counter and phase.
module traffic_lamp_blinker
    import traffic_pkg::*;
#(
    parameter int unsigned BLINK_DIV = 4
) (
    input  logic clock,
    input  logic rst,
    input  logic en,
    output logic phase
);

    localparam logic [BLINK_CNT_W-1:0] LAST = BLINK_CNT_W'(BLINK_DIV - 1);

    logic [BLINK_CNT_W-1:0] cnt_q, cnt_d;
    logic                   phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!en) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/traffic_lamp_decoder.sv
// Registers the controller state, drives one-hot lamps, measures dwell time and
// (with TRAFFIC_LAMP_CHECK_EN defined) flags illegal state transitions in err.
module traffic_lamp_decoder
    import traffic_pkg::*;
#(
    parameter int unsigned BLINK_DIV = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [1:0]       state_in,
    input  logic             clr_err,
    output logic             lamp_red,
    output logic             lamp_yellow,
    output logic             lamp_green,
    output logic [CNT_W-1:0] dwell,
    output logic             err
);

    localparam logic [CNT_W-1:0] DWELL_MAX = {CNT_W{1'b1}};

    traffic_state_e   state_s;
    traffic_state_e   prev_q;
    logic             blink_phase;
    logic             red_q, yellow_q, green_q;
    logic             red_d, yellow_d, green_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;

    assign state_s = traffic_state_e'(state_in);

    traffic_lamp_blinker #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blinker (
        .clock (clock),
        .rst   (rst),
        .en    (state_s == IDLE),
        .phase (blink_phase)
    );

    always_comb begin
        red_d    = 1'b0;
        yellow_d = 1'b0;
        green_d  = 1'b0;
        dwell_d  = '0;
        case (state_s)
            GREEN:   green_d  = 1'b1;
            YELLOW:  yellow_d = 1'b1;
            RED:     red_d    = 1'b1;
            default: yellow_d = blink_phase;
        endcase
        if (state_s == prev_q) begin
            dwell_d = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            prev_q   <= IDLE;
            red_q    <= 1'b0;
            yellow_q <= 1'b0;
            green_q  <= 1'b0;
            dwell_q  <= '0;
        end else begin
            prev_q   <= state_s;
            red_q    <= red_d;
            yellow_q <= yellow_d;
            green_q  <= green_d;
            dwell_q  <= dwell_d;
        end
    end

`ifdef TRAFFIC_LAMP_CHECK_EN
    logic err_q, err_d;

    // A fresh violation outranks a simultaneous clear.
    always_comb begin
        err_d = err_q;
        if (!is_legal(prev_q, state_s)) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_clr_err;
    assign unused_clr_err = clr_err;
    assign err            = 1'b0;
`endif

    assign lamp_red    = red_q;
    assign lamp_yellow = yellow_q;
    assign lamp_green  = green_q;
    assign dwell       = dwell_q;

endmodule

// File: tb/tb_traffic_lamp_decoder.sv
// Randomised and directed bench for traffic_lamp_decoder; two instances
// (default and BLINK_DIV=3/CNT_W=4) share stimulus and a behavioural model.
module tb_traffic_lamp_decoder;

`ifdef TRAFFIC_LAMP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clock;
    logic       rst;
    logic [1:0] state_in;
    logic       clr_err;

    logic       r0, y0, g0, e0;
    logic [7:0] d0;
    logic       r1, y1, g1, e1;
    logic [3:0] d1;

    int checks;
    int errors;

    traffic_lamp_decoder #(.BLINK_DIV(4), .CNT_W(8)) dut0 (
        .clock(clock), .rst(rst), .state_in(state_in), .clr_err(clr_err),
        .lamp_red(r0), .lamp_yellow(y0), .lamp_green(g0), .dwell(d0), .err(e0)
    );

    traffic_lamp_decoder #(.BLINK_DIV(3), .CNT_W(4)) dut1 (
        .clock(clock), .rst(rst), .state_in(state_in), .clr_err(clr_err),
        .lamp_red(r1), .lamp_yellow(y1), .lamp_green(g1), .dwell(d1), .err(e1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural model: run lengths instead of counters/phases.
    int m_prev, m_run, m_idle;
    bit ex_r, ex_g, ex_y0, ex_y1, ex_err;

    always @(posedge clock or posedge rst) begin
        if (rst) begin
            m_prev = 0; m_run = 0; m_idle = 0;
            ex_r = 0; ex_g = 0; ex_y0 = 0; ex_y1 = 0; ex_err = 0;
        end else begin
            int s;
            bit legal;
            s = int'(state_in);
            ex_r  = (s == 3);
            ex_g  = (s == 1);
            ex_y0 = (s == 2) || (s == 0 && ((m_idle / 4) % 2 == 1));
            ex_y1 = (s == 2) || (s == 0 && ((m_idle / 3) % 2 == 1));
            m_idle = (s == 0) ? m_idle + 1 : 0;
            m_run  = (s == m_prev) ? m_run + 1 : 0;
            legal  = (s == m_prev) || (s == 0) || (m_prev < 3 && s == m_prev + 1);
            if (CHK) begin
                if (!legal) ex_err = 1;
                else if (clr_err) ex_err = 0;
            end
            m_prev = s;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("red0", int'(r0), int'(ex_r));
        chk("yellow0", int'(y0), int'(ex_y0));
        chk("green0", int'(g0), int'(ex_g));
        chk("dwell0", int'(d0), (m_run > 255) ? 255 : m_run);
        chk("err0", int'(e0), int'(ex_err));
        chk("red1", int'(r1), int'(ex_r));
        chk("yellow1", int'(y1), int'(ex_y1));
        chk("green1", int'(g1), int'(ex_g));
        chk("dwell1", int'(d1), (m_run > 15) ? 15 : m_run);
        chk("err1", int'(e1), int'(ex_err));
    endtask

    task automatic cycle(input int s, input bit c);
        state_in = 2'(s);
        clr_err  = c;
        @(negedge clock);
        check_all();
    endtask

    initial begin
        logic [19:0] blink_pat;
        int cur;
        checks = 0;
        errors = 0;
        blink_pat = 20'h0F0F0;
        rst = 1'b1;
        state_in = 2'd0;
        clr_err = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check_all();
        chk("reset_dwell_lit", int'(d0), 0);
        rst = 1'b0;

        // Legal sequence
        repeat (3) cycle(0, 0);
        repeat (5) cycle(1, 0);
        chk("green_dwell_lit", int'(d0), 4);
        chk("green_lamp_lit", int'(g0), 1);
        repeat (2) cycle(2, 0);
        chk("yellow_dwell_lit", int'(d0), 1);
        repeat (4) cycle(3, 0);
        chk("red_lamp_lit", int'(r0), 1);
        chk("legal_err_lit", int'(e0), 0);

        // Blink hold
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0);
            chk("blink_lit", int'(y0), int'(blink_pat[i]));
            chk("blink_red_lit", int'(r0), 0);
        end

        // Illegal RED -> GREEN
        cycle(1, 0); cycle(2, 0); cycle(3, 0);
        cycle(1, 0);
        chk("illegal_err_lit", int'(e0), int'(CHK));
        for (int i = 0; i < 10; i++) begin
            cycle(1, 0);
            chk("sticky_err_lit", int'(e0), int'(CHK));
        end
        cycle(1, 1);
        chk("clr_err_lit", int'(e0), 0);
        cycle(2, 0);
        cycle(1, 1);
        chk("set_wins_lit", int'(e0), int'(CHK));

        // Saturation
        repeat (40) cycle(1, 0);
        chk("sat_dwell1_lit", int'(d1), 15);

        // IDLE -> RED
        cycle(0, 1);
        cycle(3, 0);
        chk("idle_red_lamp_lit", int'(r0), 1);
        chk("idle_red_err_lit", int'(e0), int'(CHK));
        repeat (3) cycle(3, 0);

        // Asynchronous reset mid-cycle with RED applied
        #1 rst = 1'b1;
        #1;
        chk("async_red", int'(r0), 0);
        chk("async_yellow", int'(y0), 0);
        chk("async_green", int'(g0), 0);
        chk("async_dwell", int'(d0), 0);
        chk("async_err", int'(e0), 0);
        #1 rst = 1'b0;
        @(negedge clock);
        check_all();

        // Randomised legal-biased walk
        cur = 0;
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 70) cur = cur;
            else if (r < 92) cur = (cur == 3) ? 0 : cur + 1;
            else cur = int'($urandom_range(0, 3));
            cycle(cur, ($urandom_range(0, 9) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
